regfile_wb_sink: RTL
====================

Name: regfile_wb_sink

Overview:
- Register-file endpoint for the write-back path.
- Accepts write requests (address + data) from the WB stage through a valid/ready handshake and buffers them in a small write queue.
- Commits queued writes to a 16x32 register array and serves two combinational read ports for decode/operand fetch, forwarding pending queued data so reads always return the architecturally newest value.
- The Freeze input stalls commits (debug halt/hold); backpressure to WB follows from queue occupancy.

Parameters:
- DEPTH, 2, write-queue entries (power of two, 2..8)
- NREGS, 16, number of architectural registers (addressed by 4 bits; r15 = return-address register written on call)
- DW, 32, data width
- ZERO_R0, 0, when 1 writes to r0 are dropped and r0 reads as 0

Ports:
- Clk input 1 system clock, rising edge
- Reset_n input 1 asynchronous active-low reset
- WrValid input 1 write request valid (from WB; high only when write-back is enabled)
- WrReady output 1 queue can accept a request this cycle
- WrAddr input 4 destination register (WB has already resolved call -> 4'hF)
- WrData input 32 write data (WB has already selected ALU/load/pc+4)
- Freeze input 1 hold: no commit from queue to array while high
- RdAddr1 input 4 read port 1 address
- RdData1 output 32 read port 1 data
- RdAddr2 input 4 read port 2 address
- RdData2 output 32 read port 2 data
- Pending output 3 queue occupancy (0..DEPTH)
- Idle output 1 queue empty

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-low, Reset_n.
- Reset (asynchronous, Reset_n low):
  - all array registers = 0, queue empty, Pending = 0, Idle = 1, WrReady = 1.
  - Reset mid-operation discards all queued writes; no partial commit.
- Enqueue:
  - An accepted write occurs on a rising edge with WrValid & WrReady.
  - The entry is appended at the tail.
  - WrReady = (Pending < DEPTH), from registered count only, with no combinational path from WrValid.
  - When full, a dequeue in the same cycle does not raise WrReady; the slot becomes visible next cycle.
- Commit:
  - On each rising edge with Freeze = 0 and Pending > 0, the head entry is written to array[addr] and popped.
  - Exactly one commit per cycle.
  - Enqueue and commit in the same cycle are both performed; Pending is unchanged.
- Latency:
  - A write accepted at edge N is in the queue after N and in the array after edge N+1, unless frozen.
  - It is visible on the read ports from the cycle after edge N, via forwarding.
- Read (combinational):
  - RdDataX = data of the youngest queue entry whose addr == RdAddrX; otherwise array[RdAddrX].
  - A write being presented this cycle (not yet accepted) is NOT forwarded.
  - With ZERO_R0 = 1, address 0 returns 0 regardless of queue contents.
- Same-address writes: ordering is preserved; the last accepted write wins, in both the array and the forwarding path.
- ZERO_R0 = 1: writes to r0 are still accepted (handshake unchanged) and consume a slot, but commit is suppressed and they are excluded from forwarding.
- Freeze:
  - The queue fills; WrReady drops when Pending == DEPTH.
  - WrValid held high while WrReady = 0 is ignored; WB must hold the request.
  - On Freeze release, draining resumes on the next edge.
- Pointers: head/tail wrap modulo DEPTH; the full/empty distinction uses the occupancy count, not pointer equality.
- Idle = (Pending == 0), registered-derived.
- Queue state machine (tracking Pending):
  - EMPTY -> PARTIAL on enqueue without commit.
  - PARTIAL -> EMPTY on a commit of the last entry with no enqueue.
  - PARTIAL -> FULL on enqueue without commit reaching DEPTH.
  - FULL -> PARTIAL on commit.

Decomposition:
- Shared package:
  - register-address width (4)
  - data width (32)
  - RA_REG = 4'hF
  - NREGS constant
  - write-request struct {addr, data} reused by WB and this block.
- One natural sub-module, wb_write_queue: DEPTH-entry FIFO with count, head/tail, and a parallel addr-match search returning youngest-hit data.
- The array, read muxes, and forwarding select stay in the top level.

Test Plan:
- Reset, then RdAddr1 = 5, RdAddr2 = 15 -> both read 0; WrReady = 1; Idle = 1.
- Write r3 = 32'h1234_5678 (one cycle) -> next cycle RdData1(r3) = 32'h12345678 via forwarding, Pending = 1. Following cycle: Pending = 0 and value read from the array.
- Freeze = 1, then writes r15 = 32'h0000_0104 and r15 = 32'h0000_0200 -> after 2 accepts WrReady = 0, Pending = 2, RdData(r15) = 32'h200. A third request is held unaccepted. Release Freeze -> two commits, array r15 = 32'h200, third write accepted the cycle after WrReady rises.
- Back-to-back writes every cycle to r1..r8 with Freeze = 0 -> never stalls (Pending ≤ 1); final array values match the sequence.
- ZERO_R0 = 1: write r0 = 32'hFFFF_FFFF -> accepted, RdData(r0) = 0 throughout, array r0 stays 0.
- Assert Reset_n low mid-stream with Pending = 2 -> immediately Pending = 0, all reads 0, no commits after release.

Source files
------------

// File: rtl/regfile_wb_sink_pkg.sv
// Shared definitions for the write-back to register-file path.
package regfile_wb_sink_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    // Return-address register, written by WB on a call
    localparam logic [ADDR_W-1:0] RA_REG = 4'hF;

    // Write request as produced by the WB stage
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Occupancy class of the write queue
    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;

endpackage

// File: rtl/regfile_wb_sink_if.sv
// Valid/ready write-request channel from the WB stage into the register file.
interface regfile_wb_sink_if
    import regfile_wb_sink_pkg::*;
();

    logic              WrValid;
    logic              WrReady;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;

    modport master (output WrValid, output WrAddr, output WrData, input WrReady);
    modport slave  (input WrValid, input WrAddr, input WrData, output WrReady);

endinterface

// File: rtl/regfile_wb_sink_wb_write_queue.sv
// DEPTH-entry write FIFO with occupancy tracking and a youngest-hit address
// search used for read forwarding. DEPTH must be a power of two so the
// pointers wrap for free.
module wb_write_queue
    import regfile_wb_sink_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wr_req_t                      push_req_i,
    input  logic                         pop_en_i,
    output wr_req_t                      head_o,
    output logic                         empty_o,
    output logic                         ready_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [ADDR_W-1:0]            rd_addr1_i,
    input  logic [ADDR_W-1:0]            rd_addr2_i,
    output logic                         hit1_o,
    output logic [DATA_W-1:0]            hit_data1_o,
    output logic                         hit2_o,
    output logic [DATA_W-1:0]            hit_data2_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    q_state_e         state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] idx;
    logic             do_pop;
    wr_req_t          mem_q [DEPTH];

    assign do_pop  = pop_en_i && (state_q != Q_EMPTY);
    assign head_o  = mem_q[head_q];
    assign empty_o = (state_q == Q_EMPTY);
    assign ready_o = (state_q != Q_FULL);
    assign count_o = count_q;

    // Next pointers, occupancy and queue state
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it holding a value (which would infer a latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (push_i) tail_d = tail_q + PTR_W'(1);
        if (do_pop) head_d = head_q + PTR_W'(1);

        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            Q_EMPTY: begin
                if (push_i) state_d = Q_PARTIAL;
            end
            Q_PARTIAL: begin
                if (do_pop && !push_i && (count_q == CNT_W'(1)))
                    state_d = Q_EMPTY;
                else if (push_i && !do_pop && (count_q == CNT_W'(DEPTH - 1)))
                    state_d = Q_FULL;
            end
            Q_FULL: begin
                if (do_pop) state_d = Q_PARTIAL;
            end
            default: state_d = Q_EMPTY;
        endcase
    end

    // Pointer, count and state registers; reset discards all queued writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Q_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail on an accepted request
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; whether an entry is live is decided solely by the occupancy count.
        // NOTE: non-blocking assignment so every register samples pre-edge values, independent of block order.
        if (push_i) mem_q[tail_q] <= push_req_i;
    end

    // Scan live entries oldest to youngest so the youngest match wins
    always_comb begin
        idx         = '0;
        hit1_o      = 1'b0;
        hit_data1_o = '0;
        hit2_o      = 1'b0;
        hit_data2_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (mem_q[idx].addr == rd_addr1_i) begin
                    hit1_o      = 1'b1;
                    hit_data1_o = mem_q[idx].data;
                end
                if (mem_q[idx].addr == rd_addr2_i) begin
                    hit2_o      = 1'b1;
                    hit_data2_o = mem_q[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Register-file endpoint for the write-back path: queues WB writes, commits
// one per cycle into the array unless frozen, and serves two combinational
// read ports that forward pending queued data.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int NREGS   = NUM_REGS,
    parameter int DW      = DATA_W,
    parameter int ZERO_R0 = 0,
    // Three bits covers DEPTH up to 4; widens only for DEPTH = 8
    parameter int PEND_W  = ($clog2(DEPTH + 1) > 3) ? $clog2(DEPTH + 1) : 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    regfile_wb_sink_if.slave  wr,
    input  logic              Freeze,
    input  logic [ADDR_W-1:0] RdAddr1,
    output logic [DW-1:0]     RdData1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DW-1:0]     RdData2,
    output logic [PEND_W-1:0] Pending,
    output logic              Idle
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_req_t          push_req;
    wr_req_t          head_req;
    logic             push;
    logic             commit;
    logic             arr_we;
    logic             q_empty;
    logic             q_ready;
    logic [CNT_W-1:0] q_count;
    logic             hit1, hit2;
    logic [DW-1:0]    hit_data1, hit_data2;
    logic [DW-1:0]    regs_q [NREGS];

    // Ready comes from registered occupancy only, never from WrValid
    assign push       = wr.WrValid && q_ready;
    assign push_req   = '{addr: wr.WrAddr, data: wr.WrData};
    assign wr.WrReady = q_ready;
    assign Idle       = q_empty;
    assign Pending    = PEND_W'(q_count);

    // r0 writes still occupy a slot when ZERO_R0 is set; only the commit is dropped
    assign commit = !Freeze && !q_empty;
    assign arr_we = commit && !((ZERO_R0 != 0) && (head_req.addr == '0));

    wb_write_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .push_i      (push),
        .push_req_i  (push_req),
        .pop_en_i    (!Freeze),
        .head_o      (head_req),
        .empty_o     (q_empty),
        .ready_o     (q_ready),
        .count_o     (q_count),
        .rd_addr1_i  (RdAddr1),
        .rd_addr2_i  (RdAddr2),
        .hit1_o      (hit1),
        .hit_data1_o (hit_data1),
        .hit2_o      (hit2),
        .hit_data2_o (hit_data2)
    );

    // Architectural array: cleared on reset, written by the committing head
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (arr_we) begin
            regs_q[head_req.addr] <= head_req.data;
        end
    end

    // Read ports: hard zero for r0 when enabled, else youngest queued hit, else array
    always_comb begin
        RdData1 = regs_q[RdAddr1];
        RdData2 = regs_q[RdAddr2];
        if (hit1) RdData1 = hit_data1;
        if (hit2) RdData2 = hit_data2;
        if ((ZERO_R0 != 0) && (RdAddr1 == '0)) RdData1 = '0;
        if ((ZERO_R0 != 0) && (RdAddr2 == '0)) RdData2 = '0;
    end

endmodule
